// File: rtl/fmadd_normalizer_pipe.sv
// fmadd_normalizer_pipe: two-stage post-adder normalizer.
// Stage 1 registers the raw sum plus its leading-zero count; stage 2 shifts and flags it.
module fmadd_normalizer_pipe #(
  parameter int std = 31,
  parameter int man = 22,
  parameter int exp = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_carry,
  input  logic [2*man+3:0]     in_mantissa,
  input  logic [exp+1:0]       in_exponent,
  input  logic                 in_sticky,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*man+3:0]     out_mantissa,
  output logic [exp+1:0]       out_exponent,
  output logic                 out_sticky,
  output logic                 out_zero,
  output logic                 out_denormal,
  output logic                 out_overflow
);

  localparam int W  = 2*man+4;
  localparam int E  = exp+2;
  localparam int LW = $clog2(W);
  localparam logic [E-1:0] OVF = E'((1 << (exp+1)) - 1);

  if (std < man + exp + 1) begin : g_bad_cfg
    $error("std too small for man/exp");
  end

  logic          s1_valid;
  logic          s1_carry;
  logic [W-1:0]  s1_mant;
  logic [E-1:0]  s1_exp;
  logic          s1_sticky;
  logic [LW-1:0] s1_lz;
  logic          s1_zero;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv & ~rst;

  logic [LW-1:0] lz;

  // Leading-zero count: the highest set bit wins.
  always_comb begin
    lz = LW'(W-1);
    for (int i = 0; i < W; i++) begin
      if (in_mantissa[i]) lz = LW'(W-1-i);
    end
  end

  // Stage 1: capture the raw sum and its leading-zero count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_carry  <= 1'b0;
      s1_mant   <= '0;
      s1_exp    <= '0;
      s1_sticky <= 1'b0;
      s1_lz     <= '0;
      s1_zero   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid  <= in_valid;
      s1_carry  <= in_carry;
      s1_mant   <= in_mantissa;
      s1_exp    <= in_exponent;
      s1_sticky <= in_sticky;
      s1_lz     <= lz;
      s1_zero   <= ~in_carry & (in_mantissa == '0);
    end
  end

  logic          lz_lt;
  logic          c_zero;
  logic          c_norm;
  logic [E:0]    e_wide;
  logic [LW-1:0] sh;
  logic [W-1:0]  n_mant;
  logic [E-1:0]  n_exp;
  logic          n_sticky;
  logic          n_zero;
  logic          n_den;
  logic          n_ovf;

  assign lz_lt  = {{(E-LW){1'b0}}, s1_lz} < s1_exp;
  assign c_zero = ~s1_carry & s1_zero;
  assign c_norm = ~s1_carry & ~s1_zero & lz_lt;

  // Stage 2 datapath: carry shift, zero, normalize or exponent-limited shift.
  always_comb begin
    n_mant   = s1_mant;
    n_sticky = s1_sticky;
    n_zero   = 1'b0;
    n_den    = 1'b0;
    e_wide   = '0;
    sh       = '0;
    unique case (1'b1)
      s1_carry: begin
        n_mant   = {1'b1, s1_mant[W-1:1]};
        n_sticky = s1_sticky | s1_mant[0];
        e_wide   = {1'b0, s1_exp} + 1'b1;
      end
      c_zero: begin
        n_mant = '0;
        n_zero = 1'b1;
      end
      c_norm: begin
        n_mant = s1_mant << s1_lz;
        e_wide = {1'b0, s1_exp} - {{(E+1-LW){1'b0}}, s1_lz};
      end
      default: begin
        sh     = (s1_exp == '0) ? '0 : s1_exp[LW-1:0] - LW'(1);
        n_mant = s1_mant << sh;
        n_den  = 1'b1;
      end
    endcase
    n_exp = e_wide[E] ? '1 : e_wide[E-1:0];
    n_ovf = e_wide[E] | (e_wide[E-1:0] >= OVF);
  end

  // Stage 2: output registers, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_mantissa <= '0;
      out_exponent <= '0;
      out_sticky   <= 1'b0;
      out_zero     <= 1'b0;
      out_denormal <= 1'b0;
      out_overflow <= 1'b0;
    end else if (s2_adv) begin
      out_valid    <= s1_valid;
      out_mantissa <= n_mant;
      out_exponent <= n_exp;
      out_sticky   <= n_sticky;
      out_zero     <= n_zero;
      out_denormal <= n_den;
      out_overflow <= n_ovf;
    end
  end

endmodule

// File: tb/tb_fmadd_normalizer_pipe.sv
// tb_fmadd_normalizer_pipe: directed plus random stimulus
// against a scoreboard fed by an arithmetic reference model.
module tb_fmadd_normalizer_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_carry;
  logic [47:0] in_mantissa;
  logic [8:0]  in_exponent;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_mantissa;
  logic [8:0]  out_exponent;
  logic        out_sticky;
  logic        out_zero;
  logic        out_denormal;
  logic        out_overflow;

  fmadd_normalizer_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_carry(in_carry), .in_mantissa(in_mantissa),
    .in_exponent(in_exponent), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mantissa(out_mantissa), .out_exponent(out_exponent),
    .out_sticky(out_sticky), .out_zero(out_zero),
    .out_denormal(out_denormal), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef logic [60:0] res_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          pops = 0;
  res_t        q[$];
  logic [8:0]  obs_exp[$];
  res_t        got;

  assign got = {out_mantissa, out_exponent, out_sticky,
                out_zero, out_denormal, out_overflow};

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, req);
    end
  endtask

  function automatic res_t pk(input logic [47:0] m, input int e,
                              input logic s, input logic z,
                              input logic d, input logic o);
    logic [8:0] ev;
    ev = e[8:0];
    return {m, ev, s, z, d, o};
  endfunction

  function automatic res_t model(input logic c, input logic [47:0] m,
                                 input logic [8:0] e, input logic s);
    logic [47:0] mo;
    logic        st, z, d;
    int          ex, lz, shv;
    st = s; z = 0; d = 0; ex = 0;
    if (c) begin
      mo = {1'b1, m[47:1]};
      st = s | m[0];
      ex = int'(e) + 1;
    end else if (m == 0) begin
      mo = '0;
      z  = 1;
    end else begin
      lz = 0;
      while (!m[47-lz]) lz++;
      if (lz < int'(e)) begin
        mo = m << lz;
        ex = int'(e) - lz;
      end else begin
        shv = (e == 0) ? 0 : int'(e) - 1;
        mo  = m << shv;
        d   = 1;
      end
    end
    if (ex > 511) ex = 511;
    return pk(mo, ex, st, z, d, ex >= 255);
  endfunction

  // Scoreboard: a handshake seen at the negedge happens at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_unexpected", 1, 0);
        else chk("sb_result", 64'(got), 64'(q.pop_front()));
        pops++;
        obs_exp.push_back(out_exponent);
      end
      if (in_valid && in_ready)
        q.push_back(model(in_carry, in_mantissa, in_exponent, in_sticky));
    end
  end

  task automatic directed(input string tag, input logic c,
                          input logic [47:0] m, input int e,
                          input logic s, input res_t req);
    int n;
    in_valid = 1; in_carry = c; in_mantissa = m;
    in_exponent = e[8:0]; in_sticky = s;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 8);
    chk({tag, "_lat"}, n, 2);
    chk(tag, 64'(got), 64'(req));
    @(posedge clk); #1;
  endtask

  task automatic feed(input int upto, inout int k);
    logic acc;
    int   budget;
    budget = 0;
    while (k < upto && budget < 20) begin
      in_valid = 1; in_carry = 1; in_mantissa = 48'h1234;
      in_exponent = 9'(k + 1); in_sticky = 0;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      budget++;
    end
    in_valid = 0;
  endtask

  initial begin
    int   k, n, base;
    logic acc;
    rst = 1; in_valid = 0; out_ready = 1;
    in_carry = 0; in_mantissa = '0; in_exponent = '0; in_sticky = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", 64'(got), 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    directed("carry", 1, 48'h8000_0000_0001, 127, 0,
             pk(48'hC000_0000_0000, 128, 1, 0, 0, 0));
    directed("norm", 0, 48'h0000_0010_0000, 100, 0,
             pk(48'h8000_0000_0000, 73, 0, 0, 0, 0));
    directed("denorm", 0, 48'h0000_0010_0000, 10, 0,
             pk(48'h0000_2000_0000, 0, 0, 0, 1, 0));
    directed("denorm_e0", 0, 48'h0000_0010_0000, 0, 0,
             pk(48'h0000_0010_0000, 0, 0, 0, 1, 0));
    directed("zero", 0, 48'h0, 50, 1,
             pk(48'h0, 0, 1, 1, 0, 0));
    directed("ovf", 1, 48'h8000_0000_0000, 254, 0,
             pk(48'hC000_0000_0000, 255, 0, 0, 0, 1));
    directed("sat", 1, 48'h8000_0000_0000, 511, 0,
             pk(48'hC000_0000_0000, 511, 0, 0, 0, 1));

    out_ready = 0;
    obs_exp.delete();
    base = pops;
    k = 0;
    feed(4, k);
    chk("bp_accepted", k, 2);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_first", 64'(got), 64'(pk(48'h8000_0000_091A, 2, 0, 0, 0, 0)));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_hold", 64'(got), 64'(pk(48'h8000_0000_091A, 2, 0, 0, 0, 0)));
    @(posedge clk); #1;
    out_ready = 1;
    feed(4, k);
    chk("bp_fed", k, 4);
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_count", pops - base, 4);
    chk("bp_order_len", obs_exp.size(), 4);
    for (int i = 0; i < 4 && i < obs_exp.size(); i++)
      chk("bp_order", obs_exp[i], i + 2);
    @(posedge clk); #1;

    out_ready = 0;
    k = 0;
    feed(2, k);
    chk("rf_fill", k, 2);
    rst = 1;
    @(negedge clk);
    chk("rf_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rf_valid", out_valid, 0);
    chk("rf_outputs", 64'(got), 0);
    @(posedge clk); #1;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rf_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    directed("post_rst", 0, 48'h0000_0010_0000, 100, 1,
             pk(48'h8000_0000_0000, 73, 1, 0, 0, 0));

    acc = 0;
    in_valid = 0;
    repeat (400) begin
      if (!in_valid || acc) begin
        in_valid    = $urandom_range(0, 3) != 0;
        in_carry    = $urandom_range(0, 3) == 0;
        in_mantissa = 48'({$urandom, $urandom} >> $urandom_range(0, 48));
        if ($urandom_range(0, 7) == 0) in_mantissa = '0;
        in_exponent = $urandom_range(0, 1) ? 9'($urandom_range(0, 60))
                                           : 9'($urandom_range(0, 511));
        in_sticky   = 1'($urandom);
      end
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
